// File: rtl/sargantana_icache_way_array.sv
// One instruction-cache way: single-port array with byte writes, optional output
// register, and a self-contained clear sweep after reset or flush.
//
// state | meaning
// INIT  | sweep writes INIT_VAL to entry[cnt] each cycle; requests are refused
// IDLE  | reads and writes are accepted whenever flush_i is low
module sargantana_icache_way_array #(
    parameter int                DATA_W   = 128,
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DATA_W-1:0]     data_o,
    output logic                  init_busy_o
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {INIT, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              rd_fire;
    logic              in_range;
    logic              cnt_last;
    logic [DATA_W-1:0] rd_data;

    assign in_range    = ({1'b0, addr_i} < (ADDR_W+1)'(DEPTH));
    assign cnt_last    = (cnt_q == ADDR_W'(DEPTH - 1));
    assign ready_o     = (state_q == IDLE) && !flush_i;
    assign accept      = req_i && ready_o;
    assign rd_fire     = accept && !we_i;
    assign init_busy_o = (state_q == INIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (flush_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage itself has no reset; the sweep defines its contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= INIT_VAL;
            end else if (accept && we_i && in_range) begin
                for (int k = 0; k < NB; k++) begin
                    if (be_i[k]) mem[addr_i][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    assign rd_data = in_range ? mem[addr_i] : INIT_VAL;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    rvalid_o <= 1'b0;
                    data_o   <= '0;
                end else begin
                    s1_valid <= rd_fire;
                    if (rd_fire) s1_data <= rd_data;
                    rvalid_o <= s1_valid;
                    if (s1_valid) data_o <= s1_data;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rvalid_o <= 1'b0;
                    data_o   <= '0;
                end else begin
                    rvalid_o <= rd_fire;
                    if (rd_fire) data_o <= rd_data;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_sargantana_icache_way_array.sv
// Bench for the icache way array: two instances (256-deep comb output, 200-deep
// registered output) run in lockstep against an array/queue reference model.
module tb_sargantana_icache_way_array;
    localparam logic [127:0] IV1 = {4{32'hC0DEF00D}};
    localparam logic [127:0] E5  = {{15{8'hAA}}, 8'h55};
    localparam logic [127:0] E6  = 128'h3C3C3C3C_00000000_3C3C3C3C_00000000;
    localparam logic [127:0] E199 = 128'hC0DEF00D_C0DEF00D_C0DEF00D_11111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [2];
    logic         flush [2];
    logic         req [2];
    logic         we [2];
    logic [15:0]  be [2];
    logic [7:0]   addr [2];
    logic [127:0] din [2];
    logic         ready [2];
    logic         rvalid [2];
    logic         busy [2];
    logic [127:0] dout [2];

    sargantana_icache_way_array #(.DATA_W(128), .DEPTH(256), .OUT_REG(0), .INIT_VAL('0)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]), .req_i(req[0]), .we_i(we[0]),
        .be_i(be[0]), .addr_i(addr[0]), .data_i(din[0]), .ready_o(ready[0]),
        .rvalid_o(rvalid[0]), .data_o(dout[0]), .init_busy_o(busy[0]));

    sargantana_icache_way_array #(.DATA_W(128), .DEPTH(200), .OUT_REG(1), .INIT_VAL(IV1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]), .req_i(req[1]), .we_i(we[1]),
        .be_i(be[1]), .addr_i(addr[1]), .data_i(din[1]), .ready_o(ready[1]),
        .rvalid_o(rvalid[1]), .data_o(dout[1]), .init_busy_o(busy[1]));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: remaining sweep cycles, contents, last delivered data,
    // and pending read results keyed by (delivery cycle, instance).
    int           dep [2];
    int           lat [2];
    logic [127:0] iv [2];
    int           left [2];
    logic [127:0] mm [2][256];
    logic [127:0] expd [2];
    logic [127:0] pend [int];

    typedef struct {
        int           d;
        bit           w;
        logic [15:0]  b;
        int           a;
        logic [127:0] wd;
        logic [127:0] exp;
    } vec_t;
    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear(input int d);
        left[d] = dep[d];
        for (int a = 0; a < 256; a++) mm[d][a] = iv[d];
    endtask

    // Called just after a negedge with inputs already driven; covers one clock edge.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 128'(ready[d]), 128'(left[d] == 0 && !flush[d]));
            if (rst[d]) begin
                model_clear(d);
                expd[d] = '0;
                for (int j = 1; j <= 2; j++)
                    if (pend.exists((cyc + j) * 2 + d)) pend.delete((cyc + j) * 2 + d);
            end else begin
                if (req[d] && left[d] == 0 && !flush[d]) begin
                    if (we[d]) begin
                        if (int'(addr[d]) < dep[d])
                            for (int k = 0; k < 16; k++)
                                if (be[d][k]) mm[d][addr[d]][8*k +: 8] = din[d][8*k +: 8];
                    end else begin
                        pend[(cyc + lat[d]) * 2 + d] = (int'(addr[d]) < dep[d]) ? mm[d][addr[d]] : iv[d];
                    end
                end
                if (flush[d]) model_clear(d);
                else if (left[d] > 0) left[d]--;
            end
        end
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit v;
            v = pend.exists(cyc * 2 + d);
            if (v) begin
                expd[d] = pend[cyc * 2 + d];
                pend.delete(cyc * 2 + d);
            end
            chk($sformatf("busy%0d", d), 128'(busy[d]), 128'(left[d] > 0));
            chk($sformatf("rvalid%0d", d), 128'(rvalid[d]), 128'(v));
            chk($sformatf("data%0d", d), dout[d], expd[d]);
        end
    endtask

    task automatic op(input int d, input bit w, input logic [15:0] b, input int a, input logic [127:0] wd);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = 8'(a); din[d] = wd;
        tick();
        req[d] = 1'b0; we[d] = 1'b0;
    endtask

    initial begin
        int bc [2];
        int rv;
        bit done;
        logic         cap_v [4];
        logic [127:0] cap_d [4];

        dep[0] = 256; dep[1] = 200;
        lat[0] = 1;   lat[1] = 2;
        iv[0] = '0;   iv[1] = IV1;

        tbl[0]  = '{0, 1'b0, 16'h0000, 0,   128'h0,         128'h0};
        tbl[1]  = '{0, 1'b0, 16'h0000, 127, 128'h0,         128'h0};
        tbl[2]  = '{0, 1'b0, 16'h0000, 255, 128'h0,         128'h0};
        tbl[3]  = '{0, 1'b1, 16'hFFFF, 5,   {16{8'hAA}},    128'h0};
        tbl[4]  = '{0, 1'b1, 16'h0001, 5,   {16{8'h55}},    128'h0};
        tbl[5]  = '{0, 1'b0, 16'h0000, 5,   128'h0,         E5};
        tbl[6]  = '{0, 1'b1, 16'hF0F0, 6,   {16{8'h3C}},    128'h0};
        tbl[7]  = '{0, 1'b0, 16'h0000, 6,   128'h0,         E6};
        tbl[8]  = '{0, 1'b1, 16'h0000, 7,   {16{8'hFF}},    128'h0};
        tbl[9]  = '{0, 1'b0, 16'h0000, 7,   128'h0,         128'h0};
        tbl[10] = '{1, 1'b0, 16'h0000, 0,   128'h0,         IV1};
        tbl[11] = '{1, 1'b1, 16'hFFFF, 230, {16{8'hFF}},    128'h0};
        tbl[12] = '{1, 1'b0, 16'h0000, 230, 128'h0,         IV1};
        tbl[13] = '{1, 1'b1, 16'h000F, 199, {16{8'h11}},    128'h0};
        tbl[14] = '{1, 1'b0, 16'h0000, 199, 128'h0,         E199};
        tbl[15] = '{1, 1'b0, 16'h0000, 198, 128'h0,         IV1};

        // Reset and init sweep length
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; flush[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
            be[d] = '0; addr[d] = '0; din[d] = '0;
            model_clear(d);
            expd[d] = '0;
        end
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(1));
            chk($sformatf("rst_ready%0d", d), 128'(ready[d]), 128'(0));
            chk($sformatf("rst_rvalid%0d", d), 128'(rvalid[d]), 128'(0));
            chk($sformatf("rst_data%0d", d), dout[d], 128'h0);
            rst[d] = 1'b0;
            bc[d] = 1;
        end
        for (int i = 0; i < 400 && (busy[0] || busy[1]); i++) begin
            tick();
            bc[0] += int'(busy[0]);
            bc[1] += int'(busy[1]);
        end
        chk("init_len0", 128'(bc[0]), 128'(256));
        chk("init_len1", 128'(bc[1]), 128'(200));

        // Table-driven reads/writes with spec-derived expected read data
        for (int i = 0; i < NV; i++) begin
            op(tbl[i].d, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd);
            if (!tbl[i].w) begin
                repeat (lat[tbl[i].d] - 1) tick();
                chk($sformatf("vec%0d", i), dout[tbl[i].d], tbl[i].exp);
            end
        end

        // Read latency
        op(0, 1'b0, 16'h0, 5, '0);
        chk("lat0_t1", 128'(rvalid[0]), 128'(1));
        op(1, 1'b0, 16'h0, 5, '0);
        chk("lat1_t1", 128'(rvalid[1]), 128'(0));
        tick();
        chk("lat1_t2", 128'(rvalid[1]), 128'(1));

        // Back-to-back reads 5, 6, 5
        for (int j = 0; j < 4; j++) begin
            req[0] = (j < 3); we[0] = 1'b0; addr[0] = (j == 1) ? 8'd6 : 8'd5;
            tick();
            cap_v[j] = rvalid[0];
            cap_d[j] = dout[0];
        end
        req[0] = 1'b0;
        chk("b2b_v0", 128'(cap_v[0]), 128'(1));
        chk("b2b_v1", 128'(cap_v[1]), 128'(1));
        chk("b2b_v2", 128'(cap_v[2]), 128'(1));
        chk("b2b_v3", 128'(cap_v[3]), 128'(0));
        chk("b2b_d0", cap_d[0], E5);
        chk("b2b_d1", cap_d[1], E6);
        chk("b2b_d2", cap_d[2], E5);

        // Flush colliding with a write
        flush[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'd9; din[0] = {16{8'hFF}}; be[0] = 16'hFFFF;
        #1;
        chk("flush_ready", 128'(ready[0]), 128'(0));
        tick();
        flush[0] = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
        bc[0] = int'(busy[0]);
        for (int i = 0; i < 400 && busy[0]; i++) begin
            tick();
            bc[0] += int'(busy[0]);
        end
        chk("flush_len", 128'(bc[0]), 128'(256));
        op(0, 1'b0, 16'h0, 9, '0);
        chk("flush_addr9", dout[0], 128'h0);

        // Flush restarted at sweep cycle 100
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        bc[0] = int'(busy[0]);
        done = 1'b0;
        for (int i = 0; i < 600 && busy[0]; i++) begin
            if (bc[0] == 100 && !done) begin
                flush[0] = 1'b1;
                done = 1'b1;
            end
            tick();
            flush[0] = 1'b0;
            bc[0] += int'(busy[0]);
        end
        chk("reflush_len", 128'(bc[0]), 128'(356));

        // Registered-output read still delivered after a flush starts
        op(1, 1'b0, 16'h0, 0, '0);
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        chk("flush_pipe_rvalid", 128'(rvalid[1]), 128'(1));
        chk("flush_pipe_busy", 128'(busy[1]), 128'(1));
        chk("flush_pipe_data", dout[1], IV1);
        for (int i = 0; i < 300 && busy[1]; i++) tick();

        // Reset right after an accepted read, OUT_REG=1
        op(1, 1'b0, 16'h0, 3, '0);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        rv = int'(rvalid[1]);
        bc[1] = int'(busy[1]);
        for (int i = 0; i < 300 && busy[1]; i++) begin
            tick();
            bc[1] += int'(busy[1]);
            rv += int'(rvalid[1]);
        end
        chk("rstrd_rvalid", 128'(rv), 128'(0));
        chk("rstrd_data", dout[1], 128'h0);
        chk("rstrd_len", 128'(bc[1]), 128'(200));

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d]   = ($urandom_range(0, 2999) == 0);
                flush[d] = ($urandom_range(0, 1499) == 0);
                req[d]   = ($urandom_range(0, 1) == 1);
                we[d]    = ($urandom_range(0, 1) == 1);
                be[d]    = 16'($urandom);
                addr[d]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(190, 255));
                din[d]   = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; flush[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sargantana_icache_way_array.md
Name: sargantana_icache_way_array

Overview:
- Parametrised single-port storage array for one instruction-cache way. Successor to the fixed 256x128 way.
- Generic depth and width, per-byte write enables, optional output register stage.
- Built-in init/flush sequencer clears every entry after reset or on request, so the cache controller needs no sweep of its own.
- Sits between the icache controller and the tag/data lookup logic, one instance per way.

Parameters:
- DATA_W, 128, entry width in bits; multiple of 8.
- DEPTH, 256, number of entries; any value >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- OUT_REG, 0, 1 adds an output register stage: read latency becomes 2.
- INIT_VAL, '0, value written to every entry during init/flush.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  single-cycle pulse; starts a full clear sweep.
- req_i  in  1  access request; qualified by ready_o.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_W/8  byte write enables, bit k covers data bits [8k+7:8k]; ignored on reads.
- addr_i  in  ADDR_W  entry index.
- data_i  in  DATA_W  write data.
- ready_o  out  1  array accepts a request this cycle.
- rvalid_o  out  1  one-cycle pulse: data_o carries read data.
- data_o  out  DATA_W  read data; holds the last read value between reads.
- init_busy_o  out  1  clear sweep in progress.

Behaviour:
- States: INIT, IDLE.
- On rst_i, at the next edge:
  - state=INIT, sweep counter=0.
  - init_busy_o=1, ready_o=0, rvalid_o=0, data_o=0.
  - All in-flight read pipeline stages are cleared.
- INIT:
  - Each cycle, INIT_VAL is written to entry[cnt] and cnt increments.
  - When cnt==DEPTH-1 is written, next state=IDLE and cnt returns to 0.
  - The sweep takes exactly DEPTH cycles. init_busy_o falls and ready_o rises in the cycle after the last write.
- IDLE:
  - ready_o = ~flush_i, combinational.
  - A request is accepted when req_i & ready_o.
- Write:
  - Only bytes with be_i[k]=1 are updated; other bytes keep their contents.
  - be_i=0 means no change.
  - No rvalid_o is produced.
- Read, OUT_REG=0: data_o updates and rvalid_o=1 at edge N+1 after acceptance at edge N.
- Read, OUT_REG=1: the same at edge N+2.
- Pipelining:
  - Back-to-back reads are accepted every cycle; rvalid_o and data_o follow in request order.
  - A write directly after a read does not disturb the pending read data.
- Read after write, same address: the next cycle's read returns the newly written bytes. No bypass is needed, because the write commits at edge N.
- Out-of-range address (addr_i >= DEPTH, only possible when DEPTH is not a power of 2):
  - Writes are ignored.
  - Reads return INIT_VAL with rvalid_o.
- flush_i in IDLE:
  - Takes priority over req_i in the same cycle; that request is not accepted (ready_o=0).
  - Next state=INIT, cnt=0.
  - A read already in the output pipeline still delivers its rvalid_o during INIT.
- flush_i during INIT: cnt restarts at 0 and the sweep again lasts DEPTH cycles from that point.
- req_i during INIT: ignored, not accepted, no side effects.
- rst_i overrides flush_i and req_i in every state.
- Counter is ADDR_W bits wide; termination uses the compare against DEPTH-1, never overflow, so DEPTH need not be a power of 2.

Test Plan:
- Reset and init, DEPTH=256:
  - Stimulus: assert rst_i 1 cycle with INIT_VAL=0.
  - Required: init_busy_o=1 for exactly 256 cycles, then ready_o=1; reading addr 0, 127 and 255 returns 0.
- Byte-masked write, DATA_W=128:
  - Stimulus: write addr 5 with data_i=all 0xAA and be_i=16'hFFFF, then write addr 5 with data_i=all 0x55 and be_i=16'h0001.
  - Required: reading addr 5 returns 0xAAAA…AA55.
- Read latency:
  - OUT_REG=0: read addr 5 accepted at cycle t gives rvalid_o at t+1.
  - OUT_REG=1: the same read gives rvalid_o at t+2.
  - Back-to-back reads of addr 5, 6, 5 return in order with 3 consecutive rvalid_o pulses.
- Flush collision:
  - Stimulus: flush_i=1 and req_i=1 (write addr 9, 0xFF) in the same cycle.
  - Required: ready_o=0 that cycle, write dropped, 256-cycle sweep follows, addr 9 reads INIT_VAL.
  - Stimulus: a second flush_i at sweep cycle 100.
  - Required: the sweep restarts and init_busy_o stays high 356 cycles total.
- Reset mid-read:
  - Stimulus: with OUT_REG=1, read accepted, then rst_i in the following cycle.
  - Required: no rvalid_o pulse, data_o=0, sweep restarts.
- Non-power-of-2 depth, DEPTH=200:
  - Required: init lasts 200 cycles.
  - A write to addr 230 is ignored; a read of addr 230 returns INIT_VAL with rvalid_o.
